alu: RTL and testbench

- RV32I execute-stage ALU for the 5-stage pipeline.
- Decodes one-hot instruction-class flags plus func3/func7 and computes the following:
  - the arithmetic/logic result, load/store address or link value;
  - the branch/jump decision and target;
  - the pipeline flush request.
- All outputs are registered (EX/MEM boundary).

---
 rtl/alu.sv | 237 +++++++++++++++++++++++
 tb/tb_alu.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu.sv
// ---------------------------------------------------------------------------
// alu -- RV32I execute-stage ALU for the 5-stage pipeline.
//
// Decodes the one-hot instruction-class flags coming out of ID together with
// func3/func7 and produces, registered at the EX/MEM boundary:
//   * the arithmetic/logic result, load/store effective address, or the
//     link value (pc+4) of a jump;
//   * the control-transfer decision and its redirect target;
//   * the IF/ID flush request plus the sequential PC of the flushing
//     instruction.
//
// Ports
//   clk, rst_n                      rising-edge clock, async active-low reset
//   pc                              PC of the instruction sitting in EX
//   func3, func7                    instruction function fields
//   imm                             sign-extended immediate from decode
//   is_Rtype .. is_auipc            one-hot instruction class flags
//   rs1, rs2                        forwarded register operands
//   branch                          control transfer taken (one cycle pulse)
//   flush                           flush IF/ID request (equal to branch)
//   alu_result                      result / address / link value
//   pc_branch                       redirect target
//   pc_flush                        pc+4 of the flushing instruction, else 0
//   misalign                        (ALU_MISALIGN_EN only) taken transfer to a
//                                   target that is not word aligned
//
// Configuration
//   ALU_MISALIGN_EN  when defined, adds the misalign output and suppresses the
//                    redirect (branch/flush/pc_branch forced to 0) for taken
//                    transfers whose target has pc_branch[1:0] != 0. When not
//                    defined the port is absent and such targets redirect
//                    normally.
//
// Only XLEN = 32 is supported.
// ---------------------------------------------------------------------------
module alu #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] pc,
    input  logic [2:0]      func3,
    input  logic [6:0]      func7,
    input  logic [XLEN-1:0] imm,
    input  logic            is_Rtype,
    input  logic            is_Itype,
    input  logic            is_load,
    input  logic            is_store,
    input  logic            is_branch,
    input  logic            is_jal,
    input  logic            is_jalr,
    input  logic            is_lui,
    input  logic            is_auipc,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            branch,
    output logic            flush,
    output logic [XLEN-1:0] alu_result,
    output logic [XLEN-1:0] pc_branch,
`ifdef ALU_MISALIGN_EN
    output logic [XLEN-1:0] pc_flush,
    output logic            misalign
`else
    output logic [XLEN-1:0] pc_flush
`endif
);

    // func3 encodings of the integer operation table
    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    // func3 encodings of the conditional branches
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // Integer operation shared by R-type and I-type. 'alt' selects sub/sra;
    // the caller decides where that bit comes from for each class.
    function automatic logic [XLEN-1:0] int_op(
        input logic [2:0]      op,
        input logic            alt,
        input logic [XLEN-1:0] a,
        input logic [XLEN-1:0] b
    );
        logic [4:0] shamt;
        shamt = b[4:0];
        case (op)
            F3_ADD:  int_op = alt ? (a - b) : (a + b);
            F3_SLL:  int_op = a << shamt;
            F3_SLT:  int_op = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            F3_SLTU: int_op = {{(XLEN-1){1'b0}}, (a < b)};
            F3_XOR:  int_op = a ^ b;
            F3_SR:   int_op = alt ? XLEN'($signed(a) >>> shamt) : (a >> shamt);
            F3_OR:   int_op = a | b;
            F3_AND:  int_op = a & b;
            default: int_op = '0;
        endcase
    endfunction

    // Branch condition; the two reserved encodings are never taken.
    function automatic logic branch_taken(
        input logic [2:0]      op,
        input logic [XLEN-1:0] a,
        input logic [XLEN-1:0] b
    );
        case (op)
            F3_BEQ:  branch_taken = (a == b);
            F3_BNE:  branch_taken = (a != b);
            F3_BLT:  branch_taken = ($signed(a) <  $signed(b));
            F3_BGE:  branch_taken = ($signed(a) >= $signed(b));
            F3_BLTU: branch_taken = (a <  b);
            F3_BGEU: branch_taken = (a >= b);
            default: branch_taken = 1'b0;
        endcase
    endfunction

    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] pc_plus_imm;
    logic [XLEN-1:0] rs1_plus_imm;
    logic [XLEN-1:0] jalr_target;
    logic            itype_alt;

    // Only func7[5] matters to this ALU; the rest of the field is collected
    // here so it is visibly intentionally ignored.
    logic            func7_unused;

    logic [XLEN-1:0] next_result;
    logic [XLEN-1:0] next_target;
    logic            next_taken;
    logic            next_redirect;
    logic [XLEN-1:0] next_target_out;
    logic [XLEN-1:0] next_seq_pc;
`ifdef ALU_MISALIGN_EN
    logic            next_misalign;
`endif

    // Shared adders. All arithmetic wraps modulo 2^32.
    assign pc_plus4     = pc + XLEN'(4);
    assign pc_plus_imm  = pc + imm;
    assign rs1_plus_imm = rs1 + imm;
    assign jalr_target  = {rs1_plus_imm[XLEN-1:1], 1'b0};

    // I-type never subtracts; only the shift-right slot uses imm[10] to pick
    // the arithmetic variant (srai).
    assign itype_alt    = (func3 == F3_SR) && imm[10];

    assign func7_unused = ^{func7[6], func7[4:0]};

    // Class decode in fixed priority order. A bubble (no flag) leaves every
    // next-state value at zero, and any output a class does not define stays
    // zero as well -- in particular pc_branch for non-control instructions.
    always_comb begin
        next_result = '0;
        next_target = '0;
        next_taken  = 1'b0;
        if (is_jalr) begin
            next_result = pc_plus4;
            next_target = jalr_target;
            next_taken  = 1'b1;
        end else if (is_jal) begin
            next_result = pc_plus4;
            next_target = pc_plus_imm;
            next_taken  = 1'b1;
        end else if (is_branch) begin
            next_target = pc_plus_imm;
            next_taken  = branch_taken(func3, rs1, rs2);
        end else if (is_load || is_store) begin
            next_result = rs1_plus_imm;
        end else if (is_lui) begin
            next_result = imm;
        end else if (is_auipc) begin
            next_result = pc_plus_imm;
        end else if (is_Rtype) begin
            next_result = int_op(func3, func7[5], rs1, rs2);
        end else if (is_Itype) begin
            next_result = int_op(func3, itype_alt, rs1, imm);
        end
    end

    // Redirect qualification. With the misalign check enabled a taken
    // transfer to a non-word-aligned target is reported instead of followed:
    // no redirect, no flush, target cleared, link value left untouched.
`ifdef ALU_MISALIGN_EN
    always_comb begin
        next_misalign   = next_taken && (next_target[1:0] != 2'b00);
        next_redirect   = next_taken && !next_misalign;
        next_target_out = next_misalign ? '0 : next_target;
        next_seq_pc     = next_redirect ? pc_plus4 : '0;
    end
`else
    always_comb begin
        next_redirect   = next_taken;
        next_target_out = next_target;
        next_seq_pc     = next_redirect ? pc_plus4 : '0;
    end
`endif

    // EX/MEM output register. branch and flush are the same decision and
    // each is a single-cycle pulse per taken instruction, because they are
    // recomputed from the next instruction every cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            branch     <= 1'b0;
            flush      <= 1'b0;
            alu_result <= '0;
            pc_branch  <= '0;
            pc_flush   <= '0;
        end else begin
            branch     <= next_redirect;
            flush      <= next_redirect;
            alu_result <= next_result;
            pc_branch  <= next_target_out;
            pc_flush   <= next_seq_pc;
        end
    end

`ifdef ALU_MISALIGN_EN
    // Registered alongside the other outputs so it lines up with them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign <= 1'b0;
        end else begin
            misalign <= next_misalign;
        end
    end
`endif

endmodule

// File: tb/tb_alu.sv
// ---------------------------------------------------------------------------
// tb_alu -- directed testbench for the RV32I execute-stage ALU.
//
// Each step drives one instruction on the falling edge, pushes the expected
// registered outputs onto a scoreboard queue, and pops/compares one rising
// edge later. Also exercises reset hold and asynchronous mid-cycle reset.
// Supports builds with or without ALU_MISALIGN_EN.
// ---------------------------------------------------------------------------
module tb_alu;

    localparam logic [8:0] C_NONE   = 9'b000000000;
    localparam logic [8:0] C_RTYPE  = 9'b000000001;
    localparam logic [8:0] C_ITYPE  = 9'b000000010;
    localparam logic [8:0] C_LOAD   = 9'b000000100;
    localparam logic [8:0] C_STORE  = 9'b000001000;
    localparam logic [8:0] C_BRANCH = 9'b000010000;
    localparam logic [8:0] C_JAL    = 9'b000100000;
    localparam logic [8:0] C_JALR   = 9'b001000000;
    localparam logic [8:0] C_LUI    = 9'b010000000;
    localparam logic [8:0] C_AUIPC  = 9'b100000000;

    typedef struct {
        string       tag;
        logic [31:0] result;
        logic        br;
        logic [31:0] target;
        logic [31:0] seq;
        logic        mis;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [31:0] pc;
    logic [2:0]  func3;
    logic [6:0]  func7;
    logic [31:0] imm;
    logic        is_Rtype, is_Itype, is_load, is_store, is_branch;
    logic        is_jal, is_jalr, is_lui, is_auipc;
    logic [31:0] rs1, rs2;
    logic        branch, flush;
    logic [31:0] alu_result, pc_branch, pc_flush;
    logic        mis_obs;

    exp_t        sb[$];
    int          compare_count;
    int          mismatch_count;

`ifdef ALU_MISALIGN_EN
    logic misalign;
    assign mis_obs = misalign;
`else
    assign mis_obs = 1'b0;
`endif

    alu #(.XLEN(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pc         (pc),
        .func3      (func3),
        .func7      (func7),
        .imm        (imm),
        .is_Rtype   (is_Rtype),
        .is_Itype   (is_Itype),
        .is_load    (is_load),
        .is_store   (is_store),
        .is_branch  (is_branch),
        .is_jal     (is_jal),
        .is_jalr    (is_jalr),
        .is_lui     (is_lui),
        .is_auipc   (is_auipc),
        .rs1        (rs1),
        .rs2        (rs2),
        .branch     (branch),
        .flush      (flush),
        .alu_result (alu_result),
        .pc_branch  (pc_branch),
`ifdef ALU_MISALIGN_EN
        .pc_flush   (pc_flush),
        .misalign   (misalign)
`else
        .pc_flush   (pc_flush)
`endif
    );

    // 10 time-unit clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts, asserts, reports.
    task automatic checkField(input string tag, input string field,
                              input logic [31:0] obs, input logic [31:0] exp);
        compare_count++;
        assert (obs === exp) else begin
            mismatch_count++;
            $error("[TB] FAIL %s.%s observed=0x%08h expected=0x%08h",
                   tag, field, obs, exp);
        end
    endtask

    // Compare every output against the oldest scoreboard entry.
    task automatic checkOutput();
        exp_t e;
        compare_count++;
        assert (sb.size() != 0) else begin
            mismatch_count++;
            $error("[TB] FAIL scoreboard observed=empty expected=entry");
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            checkField(e.tag, "alu_result", alu_result, e.result);
            checkField(e.tag, "branch", {31'd0, branch}, {31'd0, e.br});
            checkField(e.tag, "flush", {31'd0, flush}, {31'd0, e.br});
            checkField(e.tag, "pc_branch", pc_branch, e.target);
            checkField(e.tag, "pc_flush", pc_flush, e.seq);
`ifdef ALU_MISALIGN_EN
            checkField(e.tag, "misalign", {31'd0, mis_obs}, {31'd0, e.mis});
`endif
        end
    endtask

    task automatic driveInputs(input logic [8:0] cls, input logic [31:0] pc_v,
                               input logic [2:0] f3, input logic [6:0] f7,
                               input logic [31:0] imm_v, input logic [31:0] rs1_v,
                               input logic [31:0] rs2_v);
        pc        = pc_v;
        func3     = f3;
        func7     = f7;
        imm       = imm_v;
        rs1       = rs1_v;
        rs2       = rs2_v;
        is_Rtype  = cls[0];
        is_Itype  = cls[1];
        is_load   = cls[2];
        is_store  = cls[3];
        is_branch = cls[4];
        is_jal    = cls[5];
        is_jalr   = cls[6];
        is_lui    = cls[7];
        is_auipc  = cls[8];
    endtask

    // Drive on the falling edge, queue the expectation, check after the
    // following rising edge. pc_flush expectation is pc+4 when taken.
    task automatic applyStimulus(input string tag, input logic [8:0] cls,
                                 input logic [31:0] pc_v, input logic [2:0] f3,
                                 input logic [6:0] f7, input logic [31:0] imm_v,
                                 input logic [31:0] rs1_v, input logic [31:0] rs2_v,
                                 input logic [31:0] e_res, input logic e_br,
                                 input logic [31:0] e_target, input logic e_mis);
        exp_t e;
        @(negedge clk);
        driveInputs(cls, pc_v, f3, f7, imm_v, rs1_v, rs2_v);
        e.tag    = tag;
        e.result = e_res;
        e.br     = e_br;
        e.target = e_target;
        e.seq    = e_br ? pc_v + 32'd4 : 32'd0;
        e.mis    = e_mis;
        sb.push_back(e);
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    task automatic checkAllZero(input string tag);
        checkField(tag, "alu_result", alu_result, 32'd0);
        checkField(tag, "branch", {31'd0, branch}, 32'd0);
        checkField(tag, "flush", {31'd0, flush}, 32'd0);
        checkField(tag, "pc_branch", pc_branch, 32'd0);
        checkField(tag, "pc_flush", pc_flush, 32'd0);
        checkField(tag, "misalign", {31'd0, mis_obs}, 32'd0);
    endtask

    initial begin
        compare_count  = 0;
        mismatch_count = 0;
        rst_n = 1'b0;
        // A taken JAL is presented during reset; outputs must still hold 0.
        driveInputs(C_JAL, 32'h3000, 3'd0, 7'd0, 32'h40, 32'd0, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        checkAllZero("reset_hold");
        @(negedge clk);
        driveInputs(C_NONE, 32'd0, 3'd0, 7'd0, 32'd0, 32'd0, 32'd0);
        rst_n = 1'b1;

        // R-type arithmetic
        applyStimulus("add",  C_RTYPE, 32'h0, 3'b000, 7'h00, 32'h0, 32'd10, 32'd20, 32'd30, 1'b0, 32'h0, 1'b0);
        applyStimulus("sub",  C_RTYPE, 32'h0, 3'b000, 7'h20, 32'h0, 32'd10, 32'd20, 32'hFFFF_FFF6, 1'b0, 32'h0, 1'b0);
        applyStimulus("add_wrap", C_RTYPE, 32'h0, 3'b000, 7'h00, 32'h0, 32'hFFFF_FFFF, 32'd1, 32'h0, 1'b0, 32'h0, 1'b0);
        applyStimulus("sll31", C_RTYPE, 32'h0, 3'b001, 7'h00, 32'h0, 32'd1, 32'h3F, 32'h8000_0000, 1'b0, 32'h0, 1'b0);
        applyStimulus("xor",  C_RTYPE, 32'h0, 3'b100, 7'h00, 32'h0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFF00_FF00, 1'b0, 32'h0, 1'b0);
        applyStimulus("or",   C_RTYPE, 32'h0, 3'b110, 7'h00, 32'h0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFFF0_FFF0, 1'b0, 32'h0, 1'b0);
        applyStimulus("and",  C_RTYPE, 32'h0, 3'b111, 7'h00, 32'h0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 1'b0, 32'h0, 1'b0);
        applyStimulus("sra",  C_RTYPE, 32'h0, 3'b101, 7'h20, 32'h0, 32'h8000_0000, 32'd4, 32'hF800_0000, 1'b0, 32'h0, 1'b0);
        applyStimulus("srl",  C_RTYPE, 32'h0, 3'b101, 7'h00, 32'h0, 32'h8000_0000, 32'd4, 32'h0800_0000, 1'b0, 32'h0, 1'b0);
        applyStimulus("slt",  C_RTYPE, 32'h0, 3'b010, 7'h00, 32'h0, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 32'h0, 1'b0);
        applyStimulus("sltu", C_RTYPE, 32'h0, 3'b011, 7'h00, 32'h0, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 32'h0, 1'b0);

        // I-type: func7 ignored for addi, imm[10] picks srai
        applyStimulus("addi", C_ITYPE, 32'h0, 3'b000, 7'h20, 32'd5, 32'd15, 32'd99, 32'd20, 1'b0, 32'h0, 1'b0);
        applyStimulus("srli", C_ITYPE, 32'h0, 3'b101, 7'h00, 32'h004, 32'h8000_0000, 32'd0, 32'h0800_0000, 1'b0, 32'h0, 1'b0);
        applyStimulus("srai", C_ITYPE, 32'h0, 3'b101, 7'h00, 32'h404, 32'h8000_0000, 32'd0, 32'hF800_0000, 1'b0, 32'h0, 1'b0);

        // Address generation
        applyStimulus("load",  C_LOAD,  32'h0, 3'b010, 7'h00, 32'h20, 32'h1000, 32'd0, 32'h1020, 1'b0, 32'h0, 1'b0);
        applyStimulus("store", C_STORE, 32'h0, 3'b010, 7'h00, 32'h10, 32'h2000, 32'd7, 32'h2010, 1'b0, 32'h0, 1'b0);

        // Branches, pc=0x1000 imm=16
        applyStimulus("beq",  C_BRANCH, 32'h1000, 3'b000, 7'h00, 32'd16, 32'd5, 32'd5, 32'h0, 1'b1, 32'h1010, 1'b0);
        applyStimulus("bne",  C_BRANCH, 32'h1000, 3'b001, 7'h00, 32'd16, 32'd5, 32'd5, 32'h0, 1'b0, 32'h1010, 1'b0);
        applyStimulus("blt",  C_BRANCH, 32'h1000, 3'b100, 7'h00, 32'd16, 32'hFFFF_FFFF, 32'd1, 32'h0, 1'b1, 32'h1010, 1'b0);
        applyStimulus("bltu", C_BRANCH, 32'h1000, 3'b110, 7'h00, 32'd16, 32'hFFFF_FFFF, 32'd1, 32'h0, 1'b0, 32'h1010, 1'b0);
        applyStimulus("bgeu", C_BRANCH, 32'h1000, 3'b111, 7'h00, 32'd16, 32'hFFFF_FFFF, 32'd1, 32'h0, 1'b1, 32'h1010, 1'b0);
        applyStimulus("b010", C_BRANCH, 32'h1000, 3'b010, 7'h00, 32'd16, 32'd5, 32'd5, 32'h0, 1'b0, 32'h1010, 1'b0);

        // Jumps
        applyStimulus("jal",   C_JAL,  32'h3000, 3'b000, 7'h00, 32'h40, 32'd0, 32'd0, 32'h3004, 1'b1, 32'h3040, 1'b0);
        applyStimulus("jalr",  C_JALR, 32'h4000, 3'b000, 7'h00, 32'h8, 32'h5000, 32'd0, 32'h4004, 1'b1, 32'h5008, 1'b0);
        applyStimulus("jalr_b0", C_JALR, 32'h4000, 3'b000, 7'h00, 32'h0, 32'h5001, 32'd0, 32'h4004, 1'b1, 32'h5000, 1'b0);
`ifdef ALU_MISALIGN_EN
        applyStimulus("jal_mis", C_JAL, 32'h3000, 3'b000, 7'h00, 32'h2, 32'd0, 32'd0, 32'h3004, 1'b0, 32'h0, 1'b1);
`else
        applyStimulus("jal_mis", C_JAL, 32'h3000, 3'b000, 7'h00, 32'h2, 32'd0, 32'd0, 32'h3004, 1'b1, 32'h3002, 1'b0);
`endif

        // Upper immediates
        applyStimulus("lui",   C_LUI,   32'h0,    3'b000, 7'h00, 32'h1234_5000, 32'd9, 32'd9, 32'h1234_5000, 1'b0, 32'h0, 1'b0);
        applyStimulus("auipc", C_AUIPC, 32'h8000, 3'b000, 7'h00, 32'h100, 32'd0, 32'd0, 32'h8100, 1'b0, 32'h0, 1'b0);

        // Priority and bubble
        applyStimulus("prio_jalr", C_JALR | C_JAL | C_BRANCH, 32'h4000, 3'b001, 7'h00, 32'h8, 32'h5000, 32'h5000, 32'h4004, 1'b1, 32'h5008, 1'b0);
        applyStimulus("prio_load", C_LOAD | C_RTYPE, 32'h0, 3'b000, 7'h00, 32'h20, 32'h1000, 32'h7, 32'h1020, 1'b0, 32'h0, 1'b0);
        applyStimulus("bubble", C_NONE, 32'h9000, 3'b000, 7'h00, 32'h40, 32'd1, 32'd2, 32'h0, 1'b0, 32'h0, 1'b0);

        // Asynchronous reset between clock edges
        applyStimulus("pre_rst", C_JAL, 32'h3000, 3'b000, 7'h00, 32'h40, 32'd0, 32'd0, 32'h3004, 1'b1, 32'h3040, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        checkAllZero("async_rst");
        @(posedge clk);
        #1;
        checkAllZero("rst_held");
        @(negedge clk);
        driveInputs(C_NONE, 32'd0, 3'd0, 7'd0, 32'd0, 32'd0, 32'd0);
        rst_n = 1'b1;
        applyStimulus("post_rst", C_RTYPE, 32'h0, 3'b000, 7'h00, 32'h0, 32'd10, 32'd20, 32'd30, 1'b0, 32'h0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
        $finish;
    end

endmodule
